// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one iterative shift-add multiplier.
// Round-robin arbitration in IDLE, one shift-add step per CALC cycle, and a
// held response in DONE. The result is the low N product bits, or zero when
// the exact 2N-bit product does not fit in N bits.
// Optional build macro: MUL_EARLY_TERM_EN. It leaves CALC as soon as no
// multiplier bits remain. Without it, CALC always runs N cycles.
module mul_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_rs1,
  input  logic [N-1:0] req0_rs2,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_rs1,
  input  logic [N-1:0] req1_rs2,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_rd,
  output logic         rsp_ovf
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            id;
  logic            last;
  logic            grant;
  logic            accept;
  logic            last_step;
  logic            acc_ovf;

  // Grant goes to the only valid requester, or to the one not served last on a tie.
  assign grant   = (req0_valid & req1_valid) ? ~last : req1_valid;
  assign accept  = req0_ready | req1_ready;
  assign acc_ovf = |acc[2*N-1:N];

  // The step that is running now is the final one.
`ifdef MUL_EARLY_TERM_EN
  assign last_step = (cnt == CW'(N-1)) || (mplier[N-1:1] == '0);
`else
  assign last_step = (cnt == CW'(N-1));
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic, handshakes and response outputs.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_rd     = '0;
    rsp_ovf    = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~grant;
        req1_ready = req1_valid & grant;
        if (req0_ready | req1_ready) state_nxt = CALC;
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id;
        rsp_ovf   = acc_ovf;
        rsp_rd    = acc_ovf ? '0 : acc[N-1:0];
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift-add step per CALC cycle.
  // The multiplier is held at N bits: its zero upper half never affects the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      id     <= 1'b0;
      last   <= 1'b1;
    end else if (accept) begin
      mcand  <= {{N{1'b0}}, grant ? req1_rs2 : req0_rs2};
      mplier <= grant ? req1_rs1 : req0_rs1;
      acc    <= '0;
      cnt    <= '0;
      id     <= grant;
      last   <= grant;
    end else if (state == CALC) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shared-multiplier scheduler for the core's integer execute stage. Two requesters share one N-bit iterative shift-add multiplier. The block arbitrates round-robin, latches operands and sequences the multiply over multiple cycles. It returns the low N bits of the product, tagged with the requester ID, plus an overflow flag. On overflow the result is forced to zero, matching the core's existing multiply exception convention.

## Interface
- N, 16, operand and result width (N ≥ 2)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a multiply pending
- req0_ready  out  1  requester 0 accepted this cycle
- req0_rs1, req0_rs2  in  N  requester 0 operands (multiplier, multiplicand)
- req1_valid, req1_ready, req1_rs1, req1_rs2  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  requester that issued the result
- rsp_rd  out  N  product bits [N-1:0], or 0 on overflow
- rsp_ovf  out  1  product did not fit in N bits

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE: grant is combinational from valids and the `last` pointer.
  - Single valid requester: it wins.
  - Both valid: the requester ≠ `last` wins.
  - reqX_ready = (state==IDLE) & reqX_valid & grant==X. At most one ready is high per cycle.
- Accept (valid & ready):
  - Latch mcand←rs2 and mplier←rs1, zero-extended to 2N bits.
  - Clear the 2N-bit accumulator and step counter.
  - Set id←X and last←X, then go to CALC.
- CALC, each cycle:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - Leave for DONE after the final step (see Configuration).
- DONE:
  - rsp_valid=1 and rsp_ovf = |acc[2N-1:N].
  - rsp_rd = rsp_ovf ? 0 : acc[N-1:0].
  - Outputs are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- Arithmetic: the full 2N-bit product is always formed, so the accumulator never wraps. Overflow is judged on the exact product.
- Requests arriving while not in IDLE see ready=0. Requesters must hold valid and operands until accepted.

## Timing
- Reset values: req0_ready=0, req1_ready=0, rsp_valid=0, rsp_id=0, rsp_rd=0, rsp_ovf=0, state=IDLE, last=1 (req0 wins the first tie).
- Accept at edge T → CALC from T+1.
- Macro off: fixed N CALC cycles. rsp_valid rises at T+N+1.
- Back-pressure: with rsp_ready held high, the handshake completes at T+N+1 and the next accept can occur at T+N+2. Throughput is 1 multiply per N+2 cycles.
- rsp_ready low in DONE: the state, rsp_* outputs and `last` are all frozen.
- Simultaneous request in the response cycle: rsp handshake and a new valid in the same cycle. The new request is not accepted until the following IDLE cycle; no bypass.
- Reset mid-CALC or mid-DONE clears everything immediately (asynchronously). The in-flight result is dropped and the requester must re-issue.
- rst_n deassertion is synchronised externally. The block samples it as-is.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - CALC also exits when the remaining mplier == 0 after the current step.
  - Latency becomes 1 + index of the highest set bit of rs1 (1 cycle minimum, including rs1=0).
  - rsp_valid rises at T+latency+1.
- Macro undefined: CALC always takes exactly N cycles, giving data-independent timing.
- Result, overflow and arbitration are identical in both builds.

## Test plan
- Reset then single request: req0 rs1=3, rs2=5 → rsp_rd=15, rsp_id=0, rsp_ovf=0. rsp_valid at accept+17 (macro off) or accept+3 (macro on).
- Overflow: req1 rs1=0x0100, rs2=0x0100 → rsp_rd=0, rsp_ovf=1, rsp_id=1. Boundary case rs1=0xFFFF, rs2=1 → rsp_rd=0xFFFF, rsp_ovf=0.
- Contention: both valid continuously with distinct operands → grants alternate 0,1,0,1. The first grant is req0. At most one ready per cycle, and no grant outside IDLE.
- Back-pressure: rsp_ready low for 10 cycles in DONE → rsp_rd, rsp_id and rsp_ovf stable, both readys 0. Release → IDLE one cycle later, then the next accept.
- Zero operand: rs1=0, rs2=0xABCD → rsp_rd=0, rsp_ovf=0. Latency is 1 CALC cycle with MUL_EARLY_TERM_EN, N cycles without.
- Reset mid-CALC: assert rst_n=0 at step 5 → all outputs reach reset values without a clock edge. A subsequent request completes correctly.
